// File: rtl/regbank_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regbank_wr_arbiter_if
// Description : Producer handshakes, claim port and register-bank write port
//               of the register-bank write arbiter, grouped as one bundle.
//               The master modport is the producer/issue side, the slave
//               modport is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regbank_wr_arbiter_if #(
  parameter int BUS = 32,
  parameter int DIR = 4
);
  logic                  a_valid;
  logic [DIR-1:0]        a_rd;
  logic [BUS-1:0]        a_data;
  logic                  a_ready;
  logic                  m_valid;
  logic [DIR-1:0]        m_rd;
  logic [BUS-1:0]        m_data;
  logic                  m_ready;
  logic                  WE;
  logic [DIR-1:0]        RD;
  logic [BUS-1:0]        WB;
  logic                  pc_wr_err;
  logic                  claim_valid;
  logic [DIR-1:0]        claim_rd;
  logic [(2**DIR)-1:0]   busy;

  modport master (
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data, claim_valid, claim_rd,
    input  a_ready, m_ready, WE, RD, WB, pc_wr_err, busy
  );

  modport slave (
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data, claim_valid, claim_rd,
    output a_ready, m_ready, WE, RD, WB, pc_wr_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/regbank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regbank_wr_arbiter
// Description : Shares the single register-bank write port between the ALU
//               and load writeback paths. One holding slot per producer,
//               round-robin grant with an age override for same-register
//               collisions, and PC (r15) write suppression.
//               Optional busy-bit scoreboard: define REGBANK_SCOREBOARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_wr_arbiter #(
  parameter int BUS = 32,
  parameter int DIR = 4
) (
  input wire                  clk,
  input wire                  rst_n,
  regbank_wr_arbiter_if.slave wr
);

  localparam int             c_NREG  = 2**DIR;
  localparam logic [DIR-1:0] c_PC_RD = DIR'(15);

  // Holding slots (HA = ALU, HM = load)
  logic           r_a_full, r_m_full;
  logic [DIR-1:0] r_a_rd,   r_m_rd;
  logic [BUS-1:0] r_a_data, r_m_data;
  // Age tag: set when HM holds the older (or same-edge) entry; only
  // meaningful while both slots are full.
  logic           r_m_older;
  // Last-granted pointer: 1 = HM was granted last
  logic           r_lg_m;

  logic           r_we, r_err;
  logic [DIR-1:0] r_rd;
  logic [BUS-1:0] r_wb;

  logic           w_gnt_a, w_gnt_m, w_gnt_any;
  logic [DIR-1:0] w_g_rd;
  logic [BUS-1:0] w_g_data;
  logic           w_g_pc, w_wr_fire;
  logic           w_a_ready, w_m_ready;
  logic           w_acc_a, w_acc_m;
  logic           w_a_keep, w_m_keep;

  // Pick at most one full slot for this cycle's write-port grant
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_m = 1'b0;
    if (r_a_full && r_m_full) begin
      if (r_a_rd == r_m_rd) begin
        // Same destination: program order must be preserved, oldest first
        w_gnt_m = r_m_older;
        w_gnt_a = !r_m_older;
      end else begin
        w_gnt_a = r_lg_m;
        w_gnt_m = !r_lg_m;
      end
    end else begin
      w_gnt_a = r_a_full;
      w_gnt_m = r_m_full;
    end
  end

  assign w_gnt_any = w_gnt_a | w_gnt_m;
  assign w_g_rd    = w_gnt_m ? r_m_rd   : r_a_rd;
  assign w_g_data  = w_gnt_m ? r_m_data : r_a_data;
  assign w_g_pc    = (w_g_rd == c_PC_RD);
  assign w_wr_fire = w_gnt_any && !w_g_pc;

  // A slot being drained this cycle can be refilled on the same edge
  assign w_a_ready = !r_a_full || w_gnt_a;
  assign w_m_ready = !r_m_full || w_gnt_m;
  assign w_acc_a   = wr.a_valid && w_a_ready;
  assign w_acc_m   = wr.m_valid && w_m_ready;
  assign w_a_keep  = r_a_full && !w_gnt_a;
  assign w_m_keep  = r_m_full && !w_gnt_m;

  assign wr.a_ready   = w_a_ready;
  assign wr.m_ready   = w_m_ready;
  assign wr.WE        = r_we;
  assign wr.RD        = r_rd;
  assign wr.WB        = r_wb;
  assign wr.pc_wr_err = r_err;

  // Load, drain and age-track the two holding slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_full  <= 1'b0;
      r_m_full  <= 1'b0;
      r_a_rd    <= '0;
      r_m_rd    <= '0;
      r_a_data  <= '0;
      r_m_data  <= '0;
      r_m_older <= 1'b1;
      r_lg_m    <= 1'b1;
    end else begin
      if (w_acc_a) begin
        r_a_full <= 1'b1;
        r_a_rd   <= wr.a_rd;
        r_a_data <= wr.a_data;
      end else if (w_gnt_a) begin
        r_a_full <= 1'b0;
      end
      if (w_acc_m) begin
        r_m_full <= 1'b1;
        r_m_rd   <= wr.m_rd;
        r_m_data <= wr.m_data;
      end else if (w_gnt_m) begin
        r_m_full <= 1'b0;
      end
      // Same-edge captures resolve in favour of HM
      if (w_acc_a && (w_acc_m || w_m_keep)) begin
        r_m_older <= 1'b1;
      end else if (w_acc_m && w_a_keep) begin
        r_m_older <= 1'b0;
      end
      if (w_gnt_any) begin
        r_lg_m <= w_gnt_m;
      end
    end
  end

  // Drive the registered bank write port; r15 grants are swallowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      r_rd  <= '0;
      r_wb  <= '0;
    end else begin
      r_we  <= w_wr_fire;
      r_err <= w_gnt_any && w_g_pc;
      if (w_wr_fire) begin
        r_rd <= w_g_rd;
        r_wb <= w_g_data;
      end
    end
  end

`ifdef REGBANK_SCOREBOARD_EN
  logic [c_NREG-1:0] r_busy;

  for (genvar gi = 0; gi < c_NREG; gi++) begin : g_busy
    localparam logic [DIR-1:0] c_IDX = DIR'(gi);
    logic w_set, w_clr;
    assign w_set = wr.claim_valid && (wr.claim_rd == c_IDX) && (c_IDX != c_PC_RD);
    assign w_clr = w_wr_fire && (w_g_rd == c_IDX);
    // Track issued-but-unwritten destinations; a new claim beats a retire
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_busy[gi] <= 1'b0;
      end else if (w_set) begin
        r_busy[gi] <= 1'b1;
      end else if (w_clr) begin
        r_busy[gi] <= 1'b0;
      end
    end
  end

  assign wr.busy = r_busy;
`else
  logic w_unused_claim;
  assign w_unused_claim = ^{wr.claim_valid, wr.claim_rd};
  assign wr.busy        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_wr_arbiter
// Description : Self-checking bench for regbank_wr_arbiter. A slot/sequence
//               based reference model predicts every output each cycle;
//               directed scenarios add literal expectations, followed by a
//               randomized two-producer stream with a mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_wr_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_wr_arbiter_if #(.BUS(32), .DIR(4)) wr ();

  regbank_wr_arbiter #(.BUS(32), .DIR(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          full;
    logic [3:0]  rd;
    logic [31:0] data;
    int          seq;   // edge number at capture; smaller = older
  } slot_t;

  slot_t       ma, mm;
  int          edge_n;
  bit          lg_hm;
  bit          e_we, e_err;
  logic [3:0]  e_rd;
  logic [31:0] e_wb;
  logic [15:0] e_busy;
  logic [31:0] mbank [16];
  logic [31:0] dbank [16];
  bit          acc_a, acc_m;

  // 0 = no grant, 1 = HA, 2 = HM
  function automatic int pick();
    if (ma.full && mm.full) begin
      if (ma.rd == mm.rd) return (ma.seq < mm.seq) ? 1 : 2;
      return lg_hm ? 1 : 2;
    end
    if (ma.full) return 1;
    if (mm.full) return 2;
    return 0;
  endfunction

  function automatic bit exp_ready(input int who);
    int g;
    g = pick();
    if (who == 1) return !ma.full || (g == 1);
    return !mm.full || (g == 2);
  endfunction

  task automatic model_reset();
    ma.full = 0; mm.full = 0;
    lg_hm   = 1;
    e_we = 0; e_err = 0; e_rd = '0; e_wb = '0; e_busy = '0;
    acc_a = 0; acc_m = 0;
  endtask

  task automatic model_step();
    int    g;
    slot_t s;
    g     = pick();
    acc_a = wr.a_valid && exp_ready(1);
    acc_m = wr.m_valid && exp_ready(2);
    e_we  = 0;
    e_err = 0;
    if (g != 0) begin
      s = (g == 1) ? ma : mm;
      if (s.rd != 4'd15) begin
        e_we = 1; e_rd = s.rd; e_wb = s.data; mbank[s.rd] = s.data;
`ifdef REGBANK_SCOREBOARD_EN
        e_busy[s.rd] = 1'b0;
`endif
      end else begin
        e_err = 1;
      end
      lg_hm = (g == 2);
      if (g == 1) ma.full = 0; else mm.full = 0;
    end
`ifdef REGBANK_SCOREBOARD_EN
    if (wr.claim_valid && wr.claim_rd != 4'd15) e_busy[wr.claim_rd] = 1'b1;
`endif
    if (acc_a) ma = '{1'b1, wr.a_rd, wr.a_data, edge_n};
    if (acc_m) mm = '{1'b1, wr.m_rd, wr.m_data, edge_n};
    edge_n++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("WE",        64'(wr.WE),        64'(e_we));
    chk("RD",        64'(wr.RD),        64'(e_rd));
    chk("WB",        64'(wr.WB),        64'(e_wb));
    chk("pc_wr_err", 64'(wr.pc_wr_err), 64'(e_err));
    chk("a_ready",   64'(wr.a_ready),   64'(exp_ready(1)));
    chk("m_ready",   64'(wr.m_ready),   64'(exp_ready(2)));
    chk("busy",      64'(wr.busy),      64'(e_busy));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    if (wr.WE) dbank[wr.RD] = wr.WB;
    compare_all();
  endtask

  task automatic idle_inputs();
    wr.a_valid = 0; wr.m_valid = 0; wr.claim_valid = 0;
  endtask

  // Asynchronous reset asserted mid low-phase, released on a falling edge
  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_WE_low",  64'(wr.WE),   64'd0);
    chk("async_busy_0",  64'(wr.busy), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  function automatic logic [3:0] rand_rd();
    int k;
    k = $urandom_range(0, 9);
    if (k < 3) return 4'd7;
    if (k == 3) return 4'd15;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    edge_n = 0;
    wr.a_rd = '0; wr.a_data = '0; wr.m_rd = '0; wr.m_data = '0; wr.claim_rd = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    chk("rst_WE", 64'(wr.WE), 64'd0);
    chk("rst_RD", 64'(wr.RD), 64'd0);
    chk("rst_WB", 64'(wr.WB), 64'd0);
    chk("rst_a_ready", 64'(wr.a_ready), 64'd1);
    chk("rst_m_ready", 64'(wr.m_ready), 64'd1);

    // Single producer latency
    wr.a_valid = 1; wr.a_rd = 4'd3; wr.a_data = 32'hDEADBEEF;
    tick();
    chk("single_WE_edge0", 64'(wr.WE), 64'd0);
    wr.a_valid = 0;
    tick();
    chk("single_WE",  64'(wr.WE), 64'd1);
    chk("single_RD",  64'(wr.RD), 64'd3);
    chk("single_WB",  64'(wr.WB), 64'hDEADBEEF);
    tick();
    chk("single_WE_off", 64'(wr.WE), 64'd0);

    // Same-edge accept, different rd, with back-to-back ALU refill
    do_reset();
    wr.a_valid = 1; wr.a_rd = 4'd2; wr.a_data = 32'h22;
    wr.m_valid = 1; wr.m_rd = 4'd5; wr.m_data = 32'h55;
    tick();
    chk("diff_a_ready", 64'(wr.a_ready), 64'd1);
    chk("diff_m_ready", 64'(wr.m_ready), 64'd0);
    wr.a_rd = 4'd9; wr.a_data = 32'h99; wr.m_valid = 0;
    tick();
    chk("diff_RD0", 64'(wr.RD), 64'd2);
    chk("diff_WB0", 64'(wr.WB), 64'h22);
    wr.a_valid = 0;
    tick();
    chk("diff_RD1", 64'(wr.RD), 64'd5);
    tick();
    chk("diff_RD2", 64'(wr.RD), 64'd9);
    chk("diff_WB2", 64'(wr.WB), 64'h99);
    tick();
    chk("diff_WE_off", 64'(wr.WE), 64'd0);

    // Same-edge accept, same rd: HM goes first, ALU value survives
    do_reset();
    wr.a_valid = 1; wr.a_rd = 4'd7; wr.a_data = 32'd1;
    wr.m_valid = 1; wr.m_rd = 4'd7; wr.m_data = 32'd2;
    tick();
    idle_inputs();
    tick();
    chk("same_WB0", 64'(wr.WB), 64'd2);
    tick();
    chk("same_WB1", 64'(wr.WB), 64'd1);
    chk("same_bank_r7", 64'(dbank[7]), 64'd1);
    chk("model_bank_r7", 64'(mbank[7]), 64'd1);

    // Same rd, HA captured one edge earlier
    do_reset();
    wr.a_valid = 1; wr.a_rd = 4'd7; wr.a_data = 32'd1;
    tick();
    wr.a_valid = 0;
    wr.m_valid = 1; wr.m_rd = 4'd7; wr.m_data = 32'd2;
    tick();
    chk("age_WB0", 64'(wr.WB), 64'd1);
    wr.m_valid = 0;
    tick();
    chk("age_WB1", 64'(wr.WB), 64'd2);
    chk("age_bank_r7", 64'(dbank[7]), 64'd2);

    // PC protection
    do_reset();
    wr.m_valid = 1; wr.m_rd = 4'd15; wr.m_data = 32'hBAD;
    tick();
    wr.m_valid = 0;
    tick();
    chk("pc_WE",      64'(wr.WE),        64'd0);
    chk("pc_err",     64'(wr.pc_wr_err), 64'd1);
    chk("pc_m_ready", 64'(wr.m_ready),   64'd1);
    tick();
    chk("pc_err_off", 64'(wr.pc_wr_err), 64'd0);

    // Scoreboard
    do_reset();
    wr.claim_valid = 1; wr.claim_rd = 4'd4;
    tick();
    wr.claim_valid = 0;
`ifdef REGBANK_SCOREBOARD_EN
    chk("sb_set", 64'(wr.busy[4]), 64'd1);
    wr.a_valid = 1; wr.a_rd = 4'd4; wr.a_data = 32'h44;
    tick();
    wr.a_valid = 0;
    tick();
    chk("sb_clear", 64'(wr.busy[4]), 64'd0);
    wr.a_valid = 1; wr.a_rd = 4'd4; wr.a_data = 32'h45;
    tick();
    wr.a_valid = 0;
    wr.claim_valid = 1; wr.claim_rd = 4'd4;
    tick();
    wr.claim_valid = 0;
    chk("sb_set_wins", 64'(wr.busy[4]), 64'd1);
`else
    chk("sb_off_busy", 64'(wr.busy), 64'd0);
`endif

    // Reset mid-operation with HA holding an entry
    do_reset();
    wr.a_valid = 1; wr.a_rd = 4'd1; wr.a_data = 32'h11;
    tick();
    wr.a_rd = 4'd2; wr.a_data = 32'h12;
    tick();
    chk("mid_WE_before", 64'(wr.WE), 64'd1);
    do_reset();
    chk("mid_a_ready", 64'(wr.a_ready), 64'd1);
    chk("mid_m_ready", 64'(wr.m_ready), 64'd1);
    tick();
    tick();
    chk("mid_no_write", 64'(wr.WE), 64'd0);

    // Randomized two-producer stream; blocked producers hold their request
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      if (!wr.a_valid || acc_a) begin
        wr.a_valid = ($urandom_range(0, 3) != 0);
        wr.a_rd    = rand_rd();
        wr.a_data  = $urandom;
      end
      if (!wr.m_valid || acc_m) begin
        wr.m_valid = ($urandom_range(0, 3) != 0);
        wr.m_rd    = rand_rd();
        wr.m_data  = $urandom;
      end
      wr.claim_valid = ($urandom_range(0, 2) == 0);
      wr.claim_rd    = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Write-port arbiter and sequencer for the 16-entry register bank. The bank has one write port (WE/RD/WB), shared by two producers: ALU writeback and memory-load writeback. The block buffers one pending write per producer and grants the port round-robin, with an age override when both target the same register. It also keeps PC (register 15) from being overwritten through the general write port. An optional busy-bit scoreboard tracks destinations that have been issued but not yet written back.

## Interface
- bus, 32, data width
- dir, 4, register address width (2**dir registers)

- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- a_valid  in  1  ALU write request
- a_rd  in  dir  ALU destination register
- a_data  in  bus  ALU result
- a_ready  out  1  ALU holding slot can accept
- m_valid  in  1  load write request
- m_rd  in  dir  load destination register
- m_data  in  bus  load data
- m_ready  out  1  load holding slot can accept
- WE  out  1  register-bank write enable (registered)
- RD  out  dir  register-bank write address (registered)
- WB  out  bus  register-bank write data (registered)
- pc_wr_err  out  1  one-cycle pulse: a register-15 write was discarded
- claim_valid  in  1  issue stage reserves a destination
- claim_rd  in  dir  reserved destination
- busy  out  2**dir  per-register pending-write flags

## Operation
- **Holding slots:** two one-entry slots, HA and HM.
  - An accept occurs on a clock edge when valid && ready.
  - The accept loads rd/data into the slot and records an age tag.
- **Ready:** x_ready = slot empty OR slot granted this cycle. This is combinational from slot state only and never depends on x_valid.
- **Arbitration:** each cycle, among full slots.
  - One full slot: grant it.
  - Both full, different rd: grant the slot not granted last (pointer lg).
  - Both full, same rd: grant the older slot. If both were captured on the same edge, grant HM first.
  - lg updates to the granted slot.
- **Grant edge:**
  - Slot clears.
  - If slot rd != 15: WE<=1, RD<=rd, WB<=data.
  - If slot rd == 15: WE<=0 and pc_wr_err<=1. The grant slot is consumed and nothing is written.
- **No grant:** WE<=0 and pc_wr_err<=0. RD and WB hold their previous values.
- **Reset values:**
  - WE=0, RD=0, WB=0, pc_wr_err=0, busy=0.
  - Both slots empty, so a_ready=m_ready=1.
  - lg=HM, so HA wins the first different-rd tie.
- **Reset mid-operation:** slot contents are discarded and pending writes are lost. WE falls immediately (asynchronous).

## Timing
- **Latency:** accept at edge N → grant at edge N+1 → WE high during cycle N+1..N+2 → bank captures at edge N+2.
- **Single producer:** sustains one write per cycle.
- **Both producers streaming:** each sustains one write per two cycles (alternating grants).
- **Port rate:** at most one WE per cycle; grants are never lost or duplicated.
- **Retry:** a blocked producer holds valid/rd/data stable until ready is seen high on an edge.

## Configuration
- **REGBANK_SCOREBOARD_EN defined:**
  - An edge with claim_valid sets busy[claim_rd]; a claim of rd 15 is ignored.
  - A grant edge with rd != 15 clears busy[rd].
  - Simultaneous set and clear of the same rd: set wins.
  - A claim of an already-busy rd keeps it busy.
- **REGBANK_SCOREBOARD_EN undefined:**
  - busy is constant 0.
  - claim_valid and claim_rd are unused.
  - Ports remain present.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with HA full → WE=0 immediately, busy=0, a_ready=m_ready=1 after release, no write of the held entry.
- **Single producer:** a_valid with rd=3, data=0xDEADBEEF at edge 0 → WE=1, RD=3, WB=0xDEADBEEF after edge 1; WE=0 after edge 2.
- **Same-edge accept, different rd:** HA rd=2, HM rd=5 → RD=2 first (lg reset=HM), then RD=5; a_ready high in the grant cycle allows a back-to-back new ALU write.
- **Same-edge accept, same rd:** both rd=7, a_data=1, m_data=2 → writes 2 then 1; final bank r7=1. A second case with HA captured one edge earlier writes 1 then 2.
- **PC protection:** m_rd=15 → no WE, pc_wr_err pulses exactly one cycle, m_ready returns high.
- **Scoreboard (macro on):**
  - claim rd=4 → busy[4]=1.
  - Grant of rd=4 → busy[4]=0.
  - Claim rd=4 on the same edge as the grant → busy[4] stays 1.
  - With the macro off, busy stays 0.
